// File: rtl/flicker_pkg.sv
// Shared types and constants for the flicker byte transmitter.
//   state_e      : transmitter FSM states (IDLE, WAIT_ACK)
//   level_width  : width of a FIFO occupancy count able to hold 0..depth
//   DEF_*        : default data width and FIFO depth used by the modules
package flicker_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32'd8;
  localparam int unsigned DEF_FIFO_DEPTH = 32'd4;

  // Occupancy needs one bit more than the address so "full" is representable.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 32'd1;
  endfunction

endpackage

// File: rtl/flicker_fifo.sv
// Synchronous single-clock FIFO with wrap-bit pointers.
// Ports:
//   clk, reset_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write request and data (ignored while full)
//   pop_i, rdata_o    : read request and head-of-queue data (ignored while empty)
//   level_o           : registered occupancy
//   level_next_o      : occupancy after the coming edge
//   ready_o           : registered "not full"
//   empty_o           : registered "empty"
module flicker_fifo
  import flicker_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned pFIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   reset_i,
  input  logic                                   push_i,
  input  logic [pDATA_WIDTH-1:0]                 wdata_i,
  input  logic                                   pop_i,
  output logic [pDATA_WIDTH-1:0]                 rdata_o,
  output logic [level_width(pFIFO_DEPTH)-1:0]    level_o,
  output logic [level_width(pFIFO_DEPTH)-1:0]    level_next_o,
  output logic                                   ready_o,
  output logic                                   empty_o
);

  localparam int unsigned AW = $clog2(pFIFO_DEPTH);
  localparam int unsigned LW = level_width(pFIFO_DEPTH);

  logic [pDATA_WIDTH-1:0] mem_q [pFIFO_DEPTH];
  logic [pDATA_WIDTH-1:0] mem_d [pFIFO_DEPTH];
  logic [LW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ready_q, ready_d;
  logic                   empty_q, empty_d;
  logic                   push_ok_s, pop_ok_s;

  // Pointer, storage and status next-state computation.
  always_comb begin
    push_ok_s = push_i & ready_q;
    pop_ok_s  = pop_i & ~empty_q;
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Wrap bits make the difference the true occupancy, including full.
    level_d = wr_ptr_d - rd_ptr_d;
    ready_d = (level_d != LW'(pFIFO_DEPTH));
    empty_d = (level_d == '0);
  end

  // FIFO state registers; reset empties the queue and clears storage.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < int'(pFIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata_o      = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o      = level_q;
  assign level_next_o = level_d;
  assign ready_o      = ready_q;
  assign empty_o      = empty_q;

endmodule

// File: rtl/flicker_byte_tx.sv
// Transmit side of the toggle ("flicker") byte handshake.
// Bytes from a valid/ready source are queued, presented one at a time on
// data_o, announced by toggling write_flicker_o, and held until the peer
// mirrors the toggle on read_flicker_i.
// Ports:
//   clk, reset_i                  : clock, synchronous active-high reset
//   s_data_i, s_valid_i, s_ready_o: byte source handshake
//   data_o, write_flicker_o       : byte and toggle presented to the peer
//   read_flicker_i                : peer acknowledge toggle (synchronised)
//   level_o, busy_o               : queue occupancy, activity indication
//   timeout_o, error_o, clear_i   : sticky status flags and their clear
module flicker_byte_tx
  import flicker_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned pFIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned pSYNC_STAGES = 32'd2,
  parameter int unsigned pTIMEOUT     = 32'd0
) (
  input  logic                                clk,
  input  logic                                reset_i,
  input  logic [pDATA_WIDTH-1:0]              s_data_i,
  input  logic                                s_valid_i,
  output logic                                s_ready_o,
  output logic [pDATA_WIDTH-1:0]              data_o,
  output logic                                write_flicker_o,
  input  logic                                read_flicker_i,
  output logic [level_width(pFIFO_DEPTH)-1:0] level_o,
  output logic                                busy_o,
  output logic                                timeout_o,
  output logic                                error_o,
  input  logic                                clear_i
);

  localparam int unsigned   LW        = level_width(pFIFO_DEPTH);
  localparam int unsigned   CW        = (pTIMEOUT > 32'd0) ? $clog2(pTIMEOUT + 32'd1) : 32'd1;
  localparam logic [CW-1:0] TMO_LIMIT = CW'(pTIMEOUT);
  localparam bit            TMO_EN    = (pTIMEOUT != 32'd0);

  state_e                 state_q, state_d;
  logic [pDATA_WIDTH-1:0] data_q, data_d;
  logic                   wf_q, wf_d;
  logic                   rd_prev_q, rd_prev_d;
  logic [CW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic                   tmo_q, tmo_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic                   rd_s;
  logic                   flags_eq_s;
  logic                   launch_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   tmo_hit_s;
  logic                   err_set_s;
  logic [pDATA_WIDTH-1:0] fifo_rdata_s;
  logic [LW-1:0]          fifo_level_s;
  logic [LW-1:0]          fifo_level_next_s;
  logic                   fifo_ready_s;
  logic                   fifo_empty_s;

  // Peer read flag: either used directly (same-domain peer) or via a flop chain.
  if (pSYNC_STAGES == 32'd0) begin : g_nosync
    assign rd_s = read_flicker_i;
  end else begin : g_sync
    logic [pSYNC_STAGES-1:0] sync_q, sync_d;

    // Shift the peer flag one stage further along the chain.
    always_comb begin
      sync_d    = sync_q << 1'b1;
      sync_d[0] = read_flicker_i;
    end

    // Synchroniser flops.
    always_ff @(posedge clk) begin
      if (reset_i) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign rd_s = sync_q[pSYNC_STAGES-1];
  end

  flicker_fifo #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pFIFO_DEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_i      (reset_i),
    .push_i       (push_s),
    .wdata_i      (s_data_i),
    .pop_i        (pop_s),
    .rdata_o      (fifo_rdata_s),
    .level_o      (fifo_level_s),
    .level_next_o (fifo_level_next_s),
    .ready_o      (fifo_ready_s),
    .empty_o      (fifo_empty_s)
  );

  assign push_s = s_valid_i & fifo_ready_s;
  // Equal flags mean nothing is in flight: in WAIT_ACK this is the ack,
  // in IDLE it is the precondition for starting a new byte.
  assign flags_eq_s = (rd_s == wf_q);
  assign launch_s   = flags_eq_s & ~fifo_empty_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (launch_s) state_d = WAIT_ACK;
        else          state_d = IDLE;
      end
      WAIT_ACK: begin
        if (flags_eq_s && fifo_empty_s) state_d = IDLE;
        else                            state_d = WAIT_ACK;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop the head into the data register and toggle on launch.
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch_s) pop_s = 1'b1;
        else          pop_s = 1'b0;
      end
      WAIT_ACK: begin
        if (launch_s) pop_s = 1'b1;
        else          pop_s = 1'b0;
      end
      default: pop_s = 1'b0;
    endcase
    if (pop_s) begin
      data_d = fifo_rdata_s;
      wf_d   = ~wf_q;
    end else begin
      data_d = data_q;
      wf_d   = wf_q;
    end
  end

  // Timeout counter, sticky flags and busy indication.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit_s = 1'b0;
    rd_prev_d = rd_s;
    // Count only while waiting for an ack; saturate at the limit so the
    // flag fires once and a clear is not immediately undone.
    if ((state_q == WAIT_ACK) && !flags_eq_s) begin
      if (tmo_cnt_q != TMO_LIMIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
      else                        tmo_cnt_d = tmo_cnt_q;
      tmo_hit_s = TMO_EN && (tmo_cnt_q != TMO_LIMIT) && (tmo_cnt_d == TMO_LIMIT);
    end else begin
      tmo_cnt_d = '0;
      tmo_hit_s = 1'b0;
    end

    // In IDLE the peer must sit still and agree with our flag.
    err_set_s = (state_q == IDLE) && ((rd_s != rd_prev_q) || !flags_eq_s);

    if (tmo_hit_s)    tmo_d = 1'b1;
    else if (clear_i) tmo_d = 1'b0;
    else              tmo_d = tmo_q;

    if (err_set_s)    err_d = 1'b1;
    else if (clear_i) err_d = 1'b0;
    else              err_d = err_q;

    busy_d = (state_d == WAIT_ACK) || (fifo_level_next_s != '0);
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      data_q    <= '0;
      wf_q      <= 1'b0;
      rd_prev_q <= 1'b0;
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      data_q    <= data_d;
      wf_q      <= wf_d;
      rd_prev_q <= rd_prev_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready_o       = fifo_ready_s;
  assign data_o          = data_q;
  assign write_flicker_o = wf_q;
  assign level_o         = fifo_level_s;
  assign busy_o          = busy_q;
  assign timeout_o       = tmo_q;
  assign error_o         = err_q;

endmodule
